// File: rtl/datamemory_ws.sv
// Data memory for the MIPS MEM stage: byte/half/word access with sign or zero extension,
// byte-lane stores, a fixed number of wait states, and misaligned/out-of-range rejection.
module datamemory_ws #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        error,
  output logic [1:0]  dbg_state
);

  // Handshake: a request (memRead|memWrite) is taken only in IDLE and latched whole;
  // completion is a single-cycle ready pulse, with error/readData held until the next completion.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] a_addr, a_wdata;
  logic        a_rd, a_wr, a_uns;
  logic [1:0]  a_size;

  logic [31:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          req_err;
  logic [3:0]    be;
  logic [31:0]   wlane, word, rshift, ldata;
  logic          do_access;

  assign dbg_state = state;

  always_comb begin
    lane    = a_addr[1:0];
    idx     = a_addr[IW+1:2];
    req_err = 1'b0;
    if (a_rd && a_wr)                        req_err = 1'b1;
    if (a_size == 2'b11)                     req_err = 1'b1;
    if (a_size == 2'b01 && a_addr[0])        req_err = 1'b1;
    if (a_size == 2'b10 && lane != 2'b00)    req_err = 1'b1;
    if ({2'b00, a_addr[31:2]} >= 32'(DEPTH)) req_err = 1'b1;

    case (a_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = a_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase

    // Store data arrives right-aligned; move it up to its lane(s).
    wlane  = a_wdata << {lane, 3'b000};
    word   = mem[idx];
    rshift = word >> {lane, 3'b000};

    case (a_size)
      2'b00:   ldata = a_uns ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   ldata = a_uns ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ldata = word;
    endcase

    do_access = (state == BUSY) && (cnt == '0) && !req_err;
  end

  // Storage is not reset; a reset before the access edge leaves it untouched.
  always_ff @(posedge clk) begin
    if (do_access && a_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      readData <= 32'h0;
      a_addr   <= 32'h0;
      a_wdata  <= 32'h0;
      a_rd     <= 1'b0;
      a_wr     <= 1'b0;
      a_uns    <= 1'b0;
      a_size   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (memRead || memWrite) begin
            a_addr  <= addr;
            a_wdata <= writeData;
            a_rd    <= memRead;
            a_wr    <= memWrite;
            a_size  <= size;
            a_uns   <= unsignedLoad;
            cnt     <= CW'(WAIT_CYCLES);
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ready <= 1'b1;
            error <= req_err;
            if (req_err)   readData <= 32'h0;
            else if (a_rd) readData <= ldata;
            state <= RESP;
          end
        end
        RESP: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
